// File: rtl/slc3_op_pkg.sv
// Shared constants for the SLC-3 operate sequencer: opcodes, ALUK codes, FSM states, NZP layout.
// Helper functions keep the decode and condition-code rules in one place.
package slc3_op_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
  localparam logic [2:0] NZP_RESET = 3'b010;

  function automatic logic [2:0] nzp_of(input logic [15:0] r);
    logic [2:0] f;
    f = '0;
    if (r[15])
      f[NZP_N] = 1'b1;
    else if (r == 16'h0000)
      f[NZP_Z] = 1'b1;
    else
      f[NZP_P] = 1'b1;
    return f;
  endfunction

  function automatic logic [1:0] aluk_of(input logic [3:0] op);
    case (op)
      OP_AND:  return ALUK_AND;
      OP_NOT:  return ALUK_NOT;
      default: return ALUK_ADD;
    endcase
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// 8x16 register file: two combinational operand reads plus a debug read, one synchronous write.
// Reads see a write from the edge that performs it; Reset clears every entry asynchronously.
module slc3_regfile #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    ra_sel,
  input  logic [AW-1:0]    rb_sel,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] ra_dat,
  output logic [WIDTH-1:0] rb_dat,
  output logic [WIDTH-1:0] dbg_dat,
  input  logic             we,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] wdat
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wsel] <= wdat;
    end
  end

  assign ra_dat  = mem[ra_sel];
  assign rb_dat  = mem[rb_sel];
  assign dbg_dat = mem[dbg_sel];

endmodule

// File: rtl/slc3_op_sequencer.sv
// Issue/write-back engine for ADD/AND/NOT: accept -> EXEC (ALU operands) -> WB (done, write R[DR], nzp).
// One instruction per 3 cycles; instr_ready drops on accept and returns once WB (or ERR) completes.
module slc3_op_sequencer
  import slc3_op_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       aluk,
  input  logic [WIDTH-1:0] alu_out,
  output logic             done,
  output logic             illegal_op,
  output logic [2:0]       nzp,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t           state;
  logic [AW-1:0]    dr;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] opnd_b;
  logic [3:0]       op;
  logic             legal;
  logic             accept;

  assign op     = instr[15:12];
  assign legal  = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  assign accept = instr_valid && instr_ready;
  assign imm    = {{(WIDTH-5){instr[4]}}, instr[4:0]};

  always_comb begin
    opnd_b = '0;
    if (op != OP_NOT)
      opnd_b = instr[5] ? imm : rd_b;
  end

  // No write can land between accept and EXEC, so operands are read from the live instruction word.
  slc3_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_rf (
    .Clk     (Clk),
    .Reset   (Reset),
    .ra_sel  (instr[8:6]),
    .rb_sel  (instr[2:0]),
    .dbg_sel (dbg_sel),
    .ra_dat  (rd_a),
    .rb_dat  (rd_b),
    .dbg_dat (dbg_data),
    .we      (state == S_WB),
    .wsel    (dr),
    .wdat    (result)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      illegal_op  <= 1'b0;
      nzp         <= NZP_RESET;
      alu_a       <= '0;
      alu_b       <= '0;
      aluk        <= ALUK_ADD;
      dr          <= '0;
      result      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            instr_ready <= 1'b0;
            dr          <= instr[11:9];
            if (legal) begin
              state <= S_EXEC;
              alu_a <= rd_a;
              alu_b <= opnd_b;
              aluk  <= aluk_of(op);
            end else begin
              state      <= S_ERR;
              illegal_op <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          result <= alu_out;
          done   <= 1'b1;
          state  <= S_WB;
        end
        S_WB: begin
          done        <= 1'b0;
          nzp         <= nzp_of(result);
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        S_ERR: begin
          illegal_op  <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_op_sequencer.sv
// Self-checking bench for slc3_op_sequencer with an external behavioural ALU and an array-based ISA model.
// Directed vectors plus randomized instruction streams, checked at fixed cycle offsets from acceptance.
module tb_slc3_op_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  aluk;
  logic [15:0] alu_out;
  logic        done;
  logic        illegal_op;
  logic [2:0]  nzp;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_r [8];
  logic [2:0]  ref_nzp;

  typedef struct packed {
    logic        to;
    logic        done1, done2, done3;
    logic        rdy1, rdy2, rdy3;
    logic        ill1, ill2;
    logic [15:0] a, b;
    logic [1:0]  k;
  } obs_t;

  slc3_op_sequencer #(.NREGS(8), .WIDTH(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .aluk        (aluk),
    .alu_out     (alu_out),
    .done        (done),
    .illegal_op  (illegal_op),
    .nzp         (nzp),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 Clk = ~Clk;

  assign alu_out = (aluk == 2'b00) ? alu_a + alu_b :
                   (aluk == 2'b01) ? alu_a & alu_b :
                   (aluk == 2'b10) ? ~alu_a : alu_a;

  // ---------------- reference model ----------------
  function automatic logic [15:0] sext5(input logic [4:0] f);
    int v;
    v = int'(f);
    if (v >= 16) v = v - 32;
    return 16'(v);
  endfunction

  function automatic bit is_legal(input logic [15:0] ins);
    return (ins[15:12] == 4'h1) || (ins[15:12] == 4'h5) || (ins[15:12] == 4'h9);
  endfunction

  function automatic logic [15:0] model_b(input logic [15:0] ins);
    if (ins[15:12] == 4'h9) return 16'h0000;
    if (ins[5]) return sext5(ins[4:0]);
    return ref_r[ins[2:0]];
  endfunction

  function automatic logic [1:0] model_k(input logic [15:0] ins);
    if (ins[15:12] == 4'h5) return 2'b01;
    if (ins[15:12] == 4'h9) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] model_val(input logic [15:0] ins);
    logic [15:0] a;
    a = ref_r[ins[8:6]];
    case (ins[15:12])
      4'h1:    return a + model_b(ins);
      4'h5:    return a & model_b(ins);
      default: return ~a;
    endcase
  endfunction

  function automatic logic [2:0] nzp_ref(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void commit(input logic [15:0] ins);
    logic [15:0] v;
    v = model_val(ins);
    ref_r[ins[11:9]] = v;
    ref_nzp = nzp_ref(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    ref_nzp = 3'b010;
  endfunction

  function automatic logic [15:0] rand_legal();
    logic [15:0] w;
    logic [1:0]  s;
    w = 16'($urandom);
    s = 2'($urandom_range(0, 2));
    w[15:12] = (s == 2'd0) ? 4'h1 : (s == 2'd1) ? 4'h5 : 4'h9;
    return w;
  endfunction

  // ---------------- stimulus helpers (observation only) ----------------
  task automatic read_dbg(input int sel, output logic [15:0] v);
    dbg_sel = 3'(sel);
    #1;
    v = dbg_data;
  endtask

  // Returns at the falling edge of the first cycle in which instr_ready is back.
  task automatic drive_op(input logic [15:0] ins, output obs_t o);
    o = '0;
    o.to = 1'b1;
    @(negedge Clk);
    instr = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready === 1'b1) begin
        o.to = 1'b0;
        break;
      end
      @(negedge Clk);
    end
    if (o.to) begin
      instr_valid = 1'b0;
      return;
    end
    @(negedge Clk);
    instr_valid = 1'b0;
    o.done1 = done; o.ill1 = illegal_op; o.rdy1 = instr_ready;
    o.a = alu_a; o.b = alu_b; o.k = aluk;
    @(negedge Clk);
    o.done2 = done; o.ill2 = illegal_op; o.rdy2 = instr_ready;
    if (is_legal(ins)) begin
      @(negedge Clk);
      o.done3 = done; o.rdy3 = instr_ready;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v;
    Reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_sel = 3'd0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    total++; if (nzp !== 3'b010) begin bad++; $display("FAIL reset_nzp: got %b want 010", nzp); end
    total++; if ({alu_a, alu_b, aluk} !== 34'h0) begin bad++; $display("FAIL reset_alu: got a=%h b=%h k=%b want 0", alu_a, alu_b, aluk); end
    for (int i = 0; i < 8; i++) begin
      read_dbg(i, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_r%0d: got %h want 0000", i, v); end
    end
  endtask

  task automatic test_add_imm();
    obs_t o;
    logic [15:0] v;
    drive_op(16'h1265, o);
    commit(16'h1265);
    total++; if (o.to !== 1'b0) begin bad++; $display("FAIL add_imm_accept: timed out waiting for instr_ready"); end
    total++; if ({o.done1, o.done2, o.done3} !== 3'b010) begin bad++; $display("FAIL add_imm_done_timing: got %b want 010", {o.done1, o.done2, o.done3}); end
    total++; if ({o.rdy1, o.rdy2, o.rdy3} !== 3'b001) begin bad++; $display("FAIL add_imm_ready_timing: got %b want 001", {o.rdy1, o.rdy2, o.rdy3}); end
    total++; if ({o.a, o.b, o.k} !== {16'h0000, 16'h0005, 2'b00}) begin bad++; $display("FAIL add_imm_exec: got a=%h b=%h k=%b want 0000 0005 00", o.a, o.b, o.k); end
    read_dbg(1, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL add_imm_r1: got %h want 0005", v); end
    total++; if (nzp !== 3'b001) begin bad++; $display("FAIL add_imm_nzp: got %b want 001", nzp); end
  endtask

  task automatic test_neg_zero();
    logic [15:0] ins_t [2] = '{16'h14BF, 16'h5480};
    logic [15:0] val_t [2] = '{16'hFFFF, 16'h0000};
    logic [2:0]  nzp_t [2] = '{3'b100, 3'b010};
    logic [1:0]  k_t   [2] = '{2'b00, 2'b01};
    obs_t o;
    logic [15:0] v;
    for (int i = 0; i < 2; i++) begin
      drive_op(ins_t[i], o);
      commit(ins_t[i]);
      total++; if (o.to !== 1'b0 || o.done2 !== 1'b1) begin bad++; $display("FAIL negzero_retire%0d: got to=%b done=%b want 0 1", i, o.to, o.done2); end
      total++; if (o.k !== k_t[i]) begin bad++; $display("FAIL negzero_aluk%0d: got %b want %b", i, o.k, k_t[i]); end
      read_dbg(2, v);
      total++; if (v !== val_t[i]) begin bad++; $display("FAIL negzero_r2_%0d: got %h want %h", i, v, val_t[i]); end
      total++; if (nzp !== nzp_t[i]) begin bad++; $display("FAIL negzero_nzp%0d: got %b want %b", i, nzp, nzp_t[i]); end
    end
  endtask

  task automatic test_reg_not_seq();
    logic [15:0] ins_t [3] = '{16'h1641, 16'h987F, 16'h1AC4};
    int          dr_t  [3] = '{3, 4, 5};
    logic [15:0] val_t [3] = '{16'h000A, 16'hFFFA, 16'h0004};
    logic [15:0] b_t   [3] = '{16'h0005, 16'h0000, 16'hFFFA};
    logic [1:0]  k_t   [3] = '{2'b00, 2'b10, 2'b00};
    logic [2:0]  nzp_t [3] = '{3'b001, 3'b100, 3'b001};
    obs_t o;
    logic [15:0] v;
    for (int i = 0; i < 3; i++) begin
      drive_op(ins_t[i], o);
      commit(ins_t[i]);
      total++; if (o.to !== 1'b0 || o.done2 !== 1'b1) begin bad++; $display("FAIL seq_retire%0d: got to=%b done=%b want 0 1", i, o.to, o.done2); end
      total++; if (o.b !== b_t[i] || o.k !== k_t[i]) begin bad++; $display("FAIL seq_exec%0d: got b=%h k=%b want %h %b", i, o.b, o.k, b_t[i], k_t[i]); end
      read_dbg(dr_t[i], v);
      total++; if (v !== val_t[i]) begin bad++; $display("FAIL seq_r%0d: got %h want %h", dr_t[i], v, val_t[i]); end
      total++; if (nzp !== nzp_t[i]) begin bad++; $display("FAIL seq_nzp%0d: got %b want %b", i, nzp, nzp_t[i]); end
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [15:0] v;
    logic [2:0]  nzp_before;
    nzp_before = nzp;
    drive_op(16'h0E05, o);
    total++; if (o.to !== 1'b0) begin bad++; $display("FAIL illegal_accept: timed out waiting for instr_ready"); end
    total++; if ({o.ill1, o.ill2} !== 2'b10) begin bad++; $display("FAIL illegal_pulse: got %b want 10", {o.ill1, o.ill2}); end
    total++; if ({o.rdy1, o.rdy2} !== 2'b01) begin bad++; $display("FAIL illegal_ready: got %b want 01", {o.rdy1, o.rdy2}); end
    total++; if ({o.done1, o.done2} !== 2'b00) begin bad++; $display("FAIL illegal_done: got %b want 00", {o.done1, o.done2}); end
    @(negedge Clk);
    total++; if (nzp !== ref_nzp || nzp !== nzp_before) begin bad++; $display("FAIL illegal_nzp: got %b want %b", nzp, ref_nzp); end
    for (int i = 0; i < 8; i++) begin
      read_dbg(i, v);
      total++; if (v !== ref_r[i]) begin bad++; $display("FAIL illegal_r%0d: got %h want %h", i, v, ref_r[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seq [$];
    obs_t o;
    logic [15:0] v;
    seq.push_back(16'h5DA0);
    seq.push_back(16'h1DA1);
    for (int i = 0; i < 15; i++) seq.push_back(16'h1D86);
    seq.push_back(16'h9DBF);
    foreach (seq[i]) begin
      drive_op(seq[i], o);
      commit(seq[i]);
      total++; if (o.to !== 1'b0 || o.done2 !== 1'b1) begin bad++; $display("FAIL wrap_build%0d: got to=%b done=%b want 0 1", i, o.to, o.done2); end
    end
    read_dbg(6, v);
    total++; if (v !== 16'h7FFF) begin bad++; $display("FAIL wrap_setup_r6: got %h want 7fff", v); end
    drive_op(16'h1DA1, o);
    commit(16'h1DA1);
    read_dbg(6, v);
    total++; if (v !== 16'h8000) begin bad++; $display("FAIL wrap_r6: got %h want 8000", v); end
    total++; if (nzp !== 3'b100) begin bad++; $display("FAIL wrap_nzp: got %b want 100", nzp); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic [15:0] cur;
    logic [15:0] v;
    @(negedge Clk);
    cur = rand_legal();
    instr = cur;
    instr_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (instr_ready === 1'b1) begin
        acc.push_back(c);
        commit(cur);
        @(negedge Clk);
        cur = rand_legal();
        instr = cur;
      end else begin
        @(negedge Clk);
      end
    end
    instr_valid = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (acc.size() != 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++; if (acc[i] - acc[i-1] != 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 3", i, acc[i] - acc[i-1]); end
    end
    for (int i = 0; i < 8; i++) begin
      read_dbg(i, v);
      total++; if (v !== ref_r[i]) begin bad++; $display("FAIL b2b_r%0d: got %h want %h", i, v, ref_r[i]); end
    end
    total++; if (nzp !== ref_nzp) begin bad++; $display("FAIL b2b_nzp: got %b want %b", nzp, ref_nzp); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] ins, ea, eb, v;
    logic [1:0]  ek;
    logic [2:0]  nzp_old;
    for (int n = 0; n < 40; n++) begin
      ins = ($urandom_range(0, 4) == 0) ? 16'($urandom) : rand_legal();
      if (is_legal(ins)) begin
        ea = ref_r[ins[8:6]];
        eb = model_b(ins);
        ek = model_k(ins);
        commit(ins);
        drive_op(ins, o);
        total++; if (o.to !== 1'b0 || {o.done1, o.done2, o.done3} !== 3'b010) begin bad++; $display("FAIL rand_retire%0d: got to=%b done=%b want 0 010", n, o.to, {o.done1, o.done2, o.done3}); end
        total++; if ({o.a, o.b, o.k} !== {ea, eb, ek}) begin bad++; $display("FAIL rand_exec%0d: got %h %h %b want %h %h %b", n, o.a, o.b, o.k, ea, eb, ek); end
        read_dbg(int'(ins[11:9]), v);
        total++; if (v !== ref_r[ins[11:9]] || nzp !== ref_nzp) begin bad++; $display("FAIL rand_wb%0d: got r=%h nzp=%b want %h %b", n, v, nzp, ref_r[ins[11:9]], ref_nzp); end
      end else begin
        nzp_old = ref_nzp;
        drive_op(ins, o);
        total++; if (o.to !== 1'b0 || {o.ill1, o.ill2, o.done1, o.done2} !== 4'b1000) begin bad++; $display("FAIL rand_illegal%0d: got to=%b ill/done=%b want 0 1000", n, o.to, {o.ill1, o.ill2, o.done1, o.done2}); end
        read_dbg(int'(ins[11:9]), v);
        total++; if (v !== ref_r[ins[11:9]] || nzp !== nzp_old) begin bad++; $display("FAIL rand_illegal_state%0d: got r=%h nzp=%b want %h %b", n, v, nzp, ref_r[ins[11:9]], nzp_old); end
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [15:0] v;
    bit          got;
    obs_t        o;
    got = 1'b0;
    @(negedge Clk);
    instr = 16'h1265;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge Clk);
    end
    total++; if (!got) begin bad++; $display("FAIL rstwb_accept: timed out waiting for instr_ready"); end
    @(negedge Clk);
    instr_valid = 1'b0;
    @(negedge Clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rstwb_in_wb: got done=%b want 1", done); end
    Reset = 1'b1;
    #1;
    total++; if ({instr_ready, done, nzp} !== 5'b10010) begin bad++; $display("FAIL rstwb_async: got ready=%b done=%b nzp=%b want 1 0 010", instr_ready, done, nzp); end
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_dbg(i, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL rstwb_r%0d: got %h want 0000", i, v); end
    end
    total++; if (nzp !== 3'b010) begin bad++; $display("FAIL rstwb_nzp: got %b want 010", nzp); end
    drive_op(16'h1265, o);
    commit(16'h1265);
    read_dbg(1, v);
    total++; if (o.to !== 1'b0 || v !== 16'h0005) begin bad++; $display("FAIL rstwb_after: got to=%b r1=%h want 0 0005", o.to, v); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_neg_zero();
    test_reg_not_seq();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
